// File: rtl/display_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// display_sequencer_pkg
//   Shared types, limits and the 12/24-hour display conversion used by
//   display_sequencer and display_scan.
//   Contents:
//     bcd_t          one BCD digit
//     bcd2_t         two BCD digits {tens, ones}
//     HOUR_MAX       highest stored hour (24-hour form)
//     MIN10_MAX      highest tens digit of minutes/seconds
//     BCD_MAX        highest value of a BCD digit
//     SLOT_W         width of the scan slot index (covers up to 6 digits)
//     hour_disp()    stored hour -> displayed hour digits
// ---------------------------------------------------------------------------
package display_sequencer_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   localparam int   HOUR_MAX  = 23;
   localparam bcd_t MIN10_MAX = 4'd5;
   localparam bcd_t BCD_MAX   = 4'd9;

   localparam bcd_t HOUR_TENS_MAX = bcd_t'(HOUR_MAX / 10);
   localparam bcd_t HOUR_ONES_MAX = bcd_t'(HOUR_MAX % 10);

   localparam int SLOT_W = 3;

   // Converts the stored 24-hour value to what the digits show. In 12-hour
   // mode hours 0 and 12 both show as 12, so the result is always 1..12.
   function automatic bcd2_t hour_disp(input bcd2_t hour, input logic mode24);
      logic [4:0] bin;
      bcd2_t      res;
      bin = 5'(hour.tens) * 5'd10 + 5'(hour.ones);
      if (!mode24) begin
         if (bin >= 5'd12) bin = bin - 5'd12;
         if (bin == 5'd0)  bin = 5'd12;
      end
      if (bin >= 5'd20) begin
         res.tens = 4'd2;
         res.ones = 4'(bin - 5'd20);
      end else if (bin >= 5'd10) begin
         res.tens = 4'd1;
         res.ones = 4'(bin - 5'd10);
      end else begin
         res.tens = 4'd0;
         res.ones = 4'(bin);
      end
      return res;
   endfunction

endpackage

// File: rtl/display_sequencer_scan.sv
// ---------------------------------------------------------------------------
// display_scan
//   PWM phase counter, scan slot counter, one-hot digit enable and the
//   brightness window. Digit enable and separator are registered, one cycle
//   behind the phase/slot counters.
//   Ports:
//     clk_i          clock
//     reset_i        synchronous, active-high reset
//     brightness_i   lit phases per slot (0 = dark)
//     blank_lead_i   suppress the slot-0 enable (leading-zero blanking)
//     slot_o         current slot index (unregistered view of the counter)
//     digit_o        one-hot digit enable, bit 0 = leftmost digit
//     dp_n_o         active-low separator
// ---------------------------------------------------------------------------
module display_scan
   import display_sequencer_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int BRIGHT_W = 3
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [BRIGHT_W-1:0] brightness_i,
   input  logic                blank_lead_i,
   output logic [SLOT_W-1:0]   slot_o,
   output logic [DIGITS-1:0]   digit_o,
   output logic                dp_n_o
);

   logic [BRIGHT_W-1:0] phase_q, phase_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DIGITS-1:0]   digit_q, digit_d;
   logic                dp_n_q, dp_n_d;
   logic                lit;
   logic                dp_slot;

   // With brightness at its maximum the last phase is still dark.
   assign lit = (phase_q < brightness_i);

   // Separator follows hour1 and, with seconds shown, min1.
   assign dp_slot = (slot_q == SLOT_W'(1)) || ((DIGITS == 6) && (slot_q == SLOT_W'(3)));

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      phase_d = phase_q + 1'b1;
      slot_d  = slot_q;
      digit_d = '0;
      if (&phase_q) begin
         slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) begin
         digit_d[i] = lit && (slot_q == SLOT_W'(i));
      end
      // Bit 0 can only be set during slot 0, so clearing it blanks that slot.
      if (blank_lead_i) digit_d[0] = 1'b0;
      dp_n_d = !(lit && dp_slot);
   end

   // NOTE: registers are assigned with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         phase_q <= '0;
         slot_q  <= '0;
         digit_q <= '0;
         dp_n_q  <= 1'b1;
      end else begin
         phase_q <= phase_d;
         slot_q  <= slot_d;
         digit_q <= digit_d;
         dp_n_q  <= dp_n_d;
      end
   end

   assign slot_o  = slot_q;
   assign digit_o = digit_q;
   assign dp_n_o  = dp_n_q;

endmodule

// File: rtl/display_sequencer.sv
// ---------------------------------------------------------------------------
// display_sequencer
//   BCD wall clock (HH:MM or HH:MM:SS) with multiplexed digit output,
//   run-time 12/24-hour display, PM flag and PWM brightness.
//   Hours are always stored in 24-hour form; Mode24 affects display only.
//   Ports:
//     Clock        sole clock
//     Reset        synchronous, active-high
//     Tick         time-base pulse (minute for DIGITS=4, second for DIGITS=6)
//     SyncMinIn    user minute advance (no carry into the hour)
//     SyncHourIn   user hour advance
//     Mode24       1 = 24-hour display, 0 = 12-hour display
//     Brightness   lit phases per scan slot
//     Digit        one-hot digit enable, bit 0 = hour tens
//     D            BCD value of the current slot
//     DP           active-low separator
//     PM           stored hour is 12..23
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, a displayed hour tens of 0 keeps
//                            the slot-0 enable low for the whole slot.
// ---------------------------------------------------------------------------
module display_sequencer
   import display_sequencer_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int BRIGHT_W = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Tick,
   input  logic                SyncMinIn,
   input  logic                SyncHourIn,
   input  logic                Mode24,
   input  logic [BRIGHT_W-1:0] Brightness,
   output logic [DIGITS-1:0]   Digit,
   output logic [3:0]          D,
   output logic                DP,
   output logic                PM
);

   generate
      if (DIGITS != 4 && DIGITS != 6) begin : g_bad_digits
         $error("display_sequencer: DIGITS must be 4 or 6");
      end
   endgenerate

   localparam bit HAS_SEC = (DIGITS == 6);

   bcd2_t             hour_q, hour_d;
   bcd_t              min10_q, min10_d, min1_q, min1_d;
   bcd_t              sec10_q, sec10_d, sec1_q, sec1_d;
   bcd_t              d_q, slot_val;
   bcd2_t             disp_hour;
   logic [SLOT_W-1:0] slot;
   logic              blank_lead;
   logic              sec_wrap, min_wrap, tick_min, hour_inc;

   // ---------------- time counters ----------------
   assign sec_wrap = (sec1_q == BCD_MAX) && (sec10_q == MIN10_MAX);
   assign min_wrap = (min1_q == BCD_MAX) && (min10_q == MIN10_MAX);
   // A tick reaches the minute counters directly (HH:MM) or via a seconds wrap.
   assign tick_min = Tick && (!HAS_SEC || sec_wrap);
   // A user minute step never carries, and it suppresses the tick entirely,
   // so the hour moves at most once even when both sources fire.
   assign hour_inc = SyncHourIn || (!SyncMinIn && tick_min && min_wrap);

   always_comb begin
      hour_d  = hour_q;
      min10_d = min10_q;
      min1_d  = min1_q;
      sec10_d = sec10_q;
      sec1_d  = sec1_q;

      if (SyncMinIn || tick_min) begin
         if (min1_q == BCD_MAX) begin
            min1_d  = '0;
            min10_d = (min10_q == MIN10_MAX) ? '0 : min10_q + 4'd1;
         end else begin
            min1_d = min1_q + 4'd1;
         end
      end

      if (HAS_SEC) begin
         if (SyncMinIn) begin
            sec10_d = '0;
            sec1_d  = '0;
         end else if (Tick) begin
            if (sec1_q == BCD_MAX) begin
               sec1_d  = '0;
               sec10_d = (sec10_q == MIN10_MAX) ? '0 : sec10_q + 4'd1;
            end else begin
               sec1_d = sec1_q + 4'd1;
            end
         end
      end

      if (hour_inc) begin
         if (hour_q.tens == HOUR_TENS_MAX && hour_q.ones == HOUR_ONES_MAX) begin
            hour_d = '0;
         end else if (hour_q.ones == BCD_MAX) begin
            hour_d.tens = hour_q.tens + 4'd1;
            hour_d.ones = '0;
         end else begin
            hour_d.ones = hour_q.ones + 4'd1;
         end
      end
   end

   // ---------------- display path ----------------
   assign disp_hour = hour_disp(hour_q, Mode24);

`ifdef LEADING_ZERO_BLANK_EN
   assign blank_lead = (disp_hour.tens == '0);
`else
   assign blank_lead = 1'b0;
`endif

   always_comb begin
      case (slot)
         3'd0:    slot_val = disp_hour.tens;
         3'd1:    slot_val = disp_hour.ones;
         3'd2:    slot_val = min10_q;
         3'd3:    slot_val = min1_q;
         3'd4:    slot_val = sec10_q;
         3'd5:    slot_val = sec1_q;
         default: slot_val = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         hour_q  <= '{tens: 4'd1, ones: 4'd2};
         min10_q <= '0;
         min1_q  <= '0;
         sec10_q <= '0;
         sec1_q  <= '0;
         d_q     <= '0;
      end else begin
         hour_q  <= hour_d;
         min10_q <= min10_d;
         min1_q  <= min1_d;
         sec10_q <= sec10_d;
         sec1_q  <= sec1_d;
         // D is registered from the same slot count as Digit, so both change
         // on the same edge; it holds through the dark phases of the slot.
         d_q     <= slot_val;
      end
   end

   display_scan #(
      .DIGITS   (DIGITS),
      .BRIGHT_W (BRIGHT_W)
   ) u_scan (
      .clk_i        (Clock),
      .reset_i      (Reset),
      .brightness_i (Brightness),
      .blank_lead_i (blank_lead),
      .slot_o       (slot),
      .digit_o      (Digit),
      .dp_n_o       (DP)
   );

   assign D  = d_q;
   assign PM = (hour_q.tens == 4'd2) || ((hour_q.tens == 4'd1) && (hour_q.ones >= 4'd2));

endmodule

// File: tb/tb_display_sequencer.sv
// ---------------------------------------------------------------------------
// tb_display_sequencer
//   Drives one HH:MM and one HH:MM:SS instance side by side. A time/scan
//   model kept in plain integers predicts every output on every cycle; a
//   vector table and hand-written sequences check the listed corner cases.
// ---------------------------------------------------------------------------
module tb_display_sequencer;

   localparam int BW       = 3;
   localparam int SLOT_LEN = 1 << BW;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Mode24 = 1'b1;
   logic [BW-1:0] Brightness = '0;
   logic          tick4 = 0, smin4 = 0, shour4 = 0;
   logic          tick6 = 0, smin6 = 0, shour6 = 0;
   logic [3:0]    digit4, d4;
   logic [5:0]    digit6;
   logic [3:0]    d6;
   logic          dp4, pm4, dp6, pm6;

   always #5 Clock = ~Clock;

   display_sequencer #(.DIGITS(4), .BRIGHT_W(BW)) u_dut4 (
      .Clock(Clock), .Reset(Reset), .Tick(tick4), .SyncMinIn(smin4),
      .SyncHourIn(shour4), .Mode24(Mode24), .Brightness(Brightness),
      .Digit(digit4), .D(d4), .DP(dp4), .PM(pm4)
   );

   display_sequencer #(.DIGITS(6), .BRIGHT_W(BW)) u_dut6 (
      .Clock(Clock), .Reset(Reset), .Tick(tick6), .SyncMinIn(smin6),
      .SyncHourIn(shour6), .Mode24(Mode24), .Brightness(Brightness),
      .Digit(digit6), .D(d6), .DP(dp6), .PM(pm6)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n     = 0;   // scan cycles since the last reset edge
   int h4 = 12, m4 = 0, s4 = 0;
   int h6 = 12, m6 = 0, s6 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected {Digit(6), D, DP} for scan position nn and the given time.
   function automatic logic [10:0] exp_disp(input int nd, h, m, s, nn,
                                            input logic m24, input int br);
      int         dh, slot, ph;
      int         v[6];
      logic [5:0] dig;
      logic       dp, lit;
      ph   = nn % SLOT_LEN;
      slot = (nn / SLOT_LEN) % nd;
      dh   = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
      v[0] = dh / 10; v[1] = dh % 10;
      v[2] = m / 10;  v[3] = m % 10;
      v[4] = s / 10;  v[5] = s % 10;
      lit  = (ph < br);
      dig  = '0;
      if (lit) dig[slot] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 0 && v[0] == 0) dig = '0;
`endif
      dp = !(lit && (slot == 1 || (nd == 6 && slot == 3)));
      return {dig, 4'(v[slot]), dp};
   endfunction

   task automatic adv(inout int h, inout int m, inout int s, input int nd,
                      input logic t, input logic sm, input logic sh);
      bit hc;
      hc = 0;
      if (sm) begin
         m = (m + 1) % 60;
         s = 0;
      end else if (t) begin
         if (nd == 6) begin
            s = s + 1;
            if (s == 60) begin s = 0; m = m + 1; end
         end else begin
            m = m + 1;
         end
         if (m == 60) begin m = 0; hc = 1; end
      end
      if (sh || hc) h = (h + 1) % 24;
   endtask

   // One clock: predict, clock, update model, compare both instances.
   task automatic step();
      logic [10:0] e4, e6;
      logic        rst;
      rst = Reset;
      e4 = exp_disp(4, h4, m4, s4, n, Mode24, int'(Brightness));
      e6 = exp_disp(6, h6, m6, s6, n, Mode24, int'(Brightness));
      if (rst) begin
         e4 = {6'd0, 4'd0, 1'b1};
         e6 = {6'd0, 4'd0, 1'b1};
      end
      @(posedge Clock);
      #1;
      cyc++;
      if (rst) begin
         h4 = 12; m4 = 0; s4 = 0;
         h6 = 12; m6 = 0; s6 = 0;
         n  = 0;
      end else begin
         adv(h4, m4, s4, 4, tick4, smin4, shour4);
         adv(h6, m6, s6, 6, tick6, smin6, shour6);
         n++;
      end
      check($sformatf("dut4 cyc%0d", cyc), {2'b00, digit4, d4, dp4, pm4}, {e4, (h4 >= 12)});
      check($sformatf("dut6 cyc%0d", cyc), {digit6, d6, dp6, pm6}, {e6, (h6 >= 12)});
   endtask

   task automatic set_in(input int nd, input logic t, input logic sm, input logic sh);
      {tick4, smin4, shour4} = (nd == 4) ? {t, sm, sh} : 3'b000;
      {tick6, smin6, shour6} = (nd == 6) ? {t, sm, sh} : 3'b000;
   endtask

   task automatic do_reset();
      set_in(4, 0, 0, 0);
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
   endtask

   // Reach h:m:s from the 12:00:00 reset value using the user inputs.
   task automatic preset(input int nd, input int h, input int m, input int s);
      do_reset();
      for (int k = 0; k < (h + 12) % 24; k++) begin set_in(nd, 0, 0, 1); step(); end
      for (int k = 0; k < m; k++)             begin set_in(nd, 0, 1, 0); step(); end
      for (int k = 0; k < s; k++)             begin set_in(nd, 1, 0, 0); step(); end
      set_in(nd, 0, 0, 0);
   endtask

   typedef struct {
      int   nd, h, m, s;
      logic t, sm, sh, m24;
      int   dh, em, es;
      logic pm;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int         seen[6];
      logic [5:0] lg;
      logic [3:0] dv, ed;
      int         slot, ph, litcnt;
      int         dtab[4];
      vec_t       v;

      //          nd  h  m  s  t sm sh m24  dh em es pm
      vecs[0]  = '{4, 23, 59,  0, 1, 0, 0, 0, 12,  0,  0, 0};
      vecs[1]  = '{4, 10, 59,  0, 1, 1, 0, 1, 10,  0,  0, 0};
      vecs[2]  = '{4, 11, 59,  0, 1, 0, 1, 1, 12,  0,  0, 1};
      vecs[3]  = '{6,  8, 15, 42, 0, 1, 0, 1,  8, 16,  0, 0};
      vecs[4]  = '{6, 23, 59, 59, 1, 0, 0, 1,  0,  0,  0, 0};
      vecs[5]  = '{6, 11, 59, 59, 1, 0, 0, 0, 12,  0,  0, 1};
      vecs[6]  = '{4, 12, 30,  0, 0, 0, 1, 0,  1, 30,  0, 1};
      vecs[7]  = '{6,  9, 59, 30, 0, 1, 1, 1, 10,  0,  0, 0};
      vecs[8]  = '{4,  0,  5,  0, 0, 0, 0, 0, 12,  5,  0, 0};
      vecs[9]  = '{6, 12,  0, 59, 1, 0, 0, 0, 12,  1,  0, 1};
      vecs[10] = '{4, 13,  9,  0, 1, 0, 0, 0,  1, 10,  0, 1};

      // ---- reset release, 12-hour mode, brightness 7: 1,2,0,0 ----
      Mode24 = 1'b0;
      Brightness = 3'd7;
      do_reset();
      dtab = '{1, 2, 0, 0};
      for (int s = 0; s < 4; s++) begin
         litcnt = 0;
         for (int p = 0; p < SLOT_LEN; p++) begin
            step();
            ed = (p < 7) ? (4'b0001 << s) : 4'b0000;
            check($sformatf("first scan slot%0d ph%0d", s, p), {digit4, d4, dp4, pm4},
                  {ed, 4'(dtab[s]), !(s == 1 && p < 7), 1'b1});
            if (digit4 != 0) litcnt++;
         end
         check($sformatf("lit cycles slot%0d", s), litcnt, 7);
      end

      // ---- table of time-counter corner cases, read back from the scan ----
      foreach (vecs[i]) begin
         v = vecs[i];
         Mode24 = v.m24;
         Brightness = 3'd7;
         preset(v.nd, v.h, v.m, v.s);
         set_in(v.nd, v.t, v.sm, v.sh);
         step();
         set_in(v.nd, 0, 0, 0);
         step();
         seen = '{default: 0};
         for (int k = 0; k < v.nd * SLOT_LEN; k++) begin
            step();
            lg = (v.nd == 4) ? {2'b00, digit4} : digit6;
            dv = (v.nd == 4) ? d4 : d6;
            if ($countones(lg) == 1) begin
               for (int j = 0; j < 6; j++) if (lg[j]) seen[j] = int'(dv);
            end
         end
         check($sformatf("vec%0d hour", i), seen[0] * 10 + seen[1], v.dh);
         check($sformatf("vec%0d min", i), seen[2] * 10 + seen[3], v.em);
         if (v.nd == 6) check($sformatf("vec%0d sec", i), seen[4] * 10 + seen[5], v.es);
         check($sformatf("vec%0d pm", i), (v.nd == 4) ? pm4 : pm6, v.pm);
      end

      // ---- brightness 0 for two full scans, then reset mid slot 2 ----
      Mode24 = 1'b1;
      Brightness = 3'd0;
      do_reset();
      litcnt = 0;
      for (int k = 0; k < 2 * 6 * SLOT_LEN; k++) begin
         step();
         if (digit6 != 0 || dp6 != 1'b1) litcnt++;
      end
      check("dark scans lit count", litcnt, 0);
      Brightness = 3'd7;
      set_in(6, 1, 0, 0);
      for (int k = 0; k < 2 * SLOT_LEN + 4; k++) step();
      set_in(6, 0, 0, 0);
      Reset = 1'b1;
      step();
      check("mid-scan reset outputs", {digit6, d6, dp6, pm6}, {6'd0, 4'd0, 1'b1, 1'b1});
      Reset = 1'b0;
      step();
      check("after reset slot0", {digit6, d6}, {6'b000001, 4'd1});
      for (int k = 0; k < 6 * SLOT_LEN; k++) step();

      // ---- randomized traffic against the model ----
      for (int k = 0; k < 4000; k++) begin
         Brightness = BW'($urandom);
         if ($urandom_range(0, 15) == 0) Mode24 = ~Mode24;
         tick4  = ($urandom_range(0, 2) == 0);
         smin4  = ($urandom_range(0, 15) == 0);
         shour4 = ($urandom_range(0, 9) == 0);
         tick6  = ($urandom_range(0, 1) == 0);
         smin6  = ($urandom_range(0, 20) == 0);
         shour6 = ($urandom_range(0, 9) == 0);
         Reset  = ($urandom_range(0, 399) == 0);
         step();
      end
      Reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
